// File: rtl/msk_pkg.sv
// Shared constants and FSM encoding for the masked state loader.
// Holds the default word geometry and the counter width helper.
package msk_pkg;

  localparam int W_DEF  = 32;
  localparam int NW_DEF = 4;
  localparam int CNT_W  = $clog2(NW_DEF);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } ld_state_e;

  function automatic int cnt_width(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/msk_encode.sv
// Boolean masking of one unmasked word into d shares per bit.
// Bit j lands in sh_o[j*d +: d]; share 0 carries the masked value.
module msk_encode #(
  parameter int d = 2,
  parameter int W = 32
) (
  input  logic [W-1:0]       data_i,
  input  logic [(d-1)*W-1:0] rnd_i,
  output logic [W*d-1:0]     sh_o
);

  // shares 1..d-1 are the raw masks, share 0 folds them into the data
  always_comb begin
    sh_o = '0;
    for (int j = 0; j < W; j++) begin
      sh_o[j*d] = data_i[j];
      for (int k = 1; k < d; k++) begin
        sh_o[j*d+k] = rnd_i[(k-1)*W+j];
        sh_o[j*d]   = sh_o[j*d] ^ rnd_i[(k-1)*W+j];
      end
    end
  end

endmodule

// File: rtl/msk_state_loader.sv
// Collects NW unmasked words, masks each on entry, and hands a full
// bitsliced shared state to the masked datapath via valid/ready.
module msk_state_loader
  import msk_pkg::*;
#(
  parameter int d  = 2,
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic [(d-1)*W-1:0]    rnd,
  input  logic                  rnd_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NW*W*d-1:0]     sh_state
);

  localparam int CW = cnt_width(NW);
  localparam int WB = W * d;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  ld_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NW*WB-1:0]  sh_q;
  logic [WB-1:0]     enc;
  logic              run_q;
  logic              accept;
  logic              wr_en;

  msk_encode #(
    .d (d),
    .W (W)
  ) u_enc (
    .data_i (in_data),
    .rnd_i  (rnd),
    .sh_o   (enc)
  );

  // run_q keeps in_ready low while reset is held and one edge after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // FSM state and slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: clear wins over both handshakes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            wr_en = 1'b1;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = FULL;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) state_d = LOAD;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // handshake outputs decoded from the registered state
  always_comb begin
    in_ready  = run_q & (state_q == LOAD) & rnd_valid;
    out_valid = (state_q == FULL);
    accept    = in_valid & in_ready;
  end

  // only encoded shares are stored; unwritten slots keep old shares
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      for (int s = 0; s < NW; s++) begin
        if (wr_en && cnt_q == CW'(s)) sh_q[s*WB +: WB] <= enc;
      end
    end
  end

  assign sh_state = sh_q;

endmodule

// File: doc/msk_state_loader.md
MSK_STATE_LOADER -- requirements
Module: msk_state_loader

Interface
REQ-001 Parameter d, default 2: number of shares per bit (d >= 2).
REQ-002 Parameter W, default 32: unmasked input word width.
REQ-003 Parameter NW, default 4: words per state, giving a 128-bit Clyde state.
REQ-004 clk  input  1: single clock; all flops on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 clear  input  1: synchronous abort of a partial load.
REQ-007 in_valid  input  1: in_data holds a word.
REQ-008 in_ready  output  1: loader accepts a word this cycle.
REQ-009 in_data  input  W: unmasked word.
REQ-010 rnd  input  (d-1)*W: fresh randomness for masking the current word.
REQ-011 rnd_valid  input  1: rnd is fresh this cycle.
REQ-012 out_valid  output  1: sh_state holds a complete shared state.
REQ-013 out_ready  input  1: downstream masked datapath (key-addition XOR stage) takes the state.
REQ-014 sh_state  output  NW*W*d: bitsliced sharing; bit i occupies sh_state[i*d +: d], share 0 at the LSB; same share layout as the masked XOR gadget inputs.

Function
REQ-015 Encoding: for bit j of the word, shares 1..d-1 SHALL equal rnd[(k-1)*W+j] for k = 1..d-1; share 0 SHALL equal in_data[j] XOR all those rnd bits.
REQ-016 Unmasked in_data SHALL never be registered; only the encoded shares are stored.
REQ-017 FSM states: LOAD and FULL.
REQ-018 in_ready SHALL equal (state==LOAD) AND rnd_valid; it depends on no output handshake.
REQ-019 A word is accepted when in_valid AND in_ready; it SHALL be written to word slot cnt (slot 0 = state bits [W-1:0]), and cnt SHALL increment.
REQ-020 Accepting the word at cnt==NW-1: cnt SHALL wrap to 0, state SHALL go to FULL, and out_valid SHALL rise on the next cycle (latency 1 from the last accept).
REQ-021 In FULL, out_valid SHALL be 1 and sh_state SHALL hold stable until out_ready=1; the cycle after out_ready=1 the FSM SHALL be in LOAD and out_valid SHALL be 0.
REQ-022 In FULL, in_valid SHALL be ignored and in_ready SHALL be 0.
REQ-023 When rnd_valid=0 in LOAD, no word SHALL be accepted, even with in_valid=1; cnt SHALL hold.
REQ-024 clear=1 SHALL take priority over accept and output handshakes: the next state is LOAD with cnt=0 and out_valid=0; stored shares are not required to be zeroed.
REQ-025 Slots not yet written in the current load SHALL keep their previous contents; out_valid SHALL never assert on a partial state.

Reset
REQ-026 While rst_n=0, asynchronously: state=LOAD, cnt=0, out_valid=0, and all sh_state bits = 0.
REQ-027 Reset asserted mid-load SHALL discard the partial state; the first accept after release SHALL write slot 0.
REQ-028 in_ready during reset SHALL be 0.

Structure
REQ-029 A shared package msk_pkg SHALL hold the W and NW defaults, the FSM state encoding, and the cnt width constant (clog2 of NW).
REQ-030 One combinational sub-module, msk_encode (parameters d and W), SHALL implement REQ-015; the FSM, counter and state register SHALL stay in msk_state_loader.
REQ-031 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-032 d=2, rnd=0 every cycle, words 0x00000001, 0x00000002, 0x00000003, 0x00000004 on consecutive cycles -> out_valid on cycle 5; share 0 of bit 0 = 1, share 1 = 0 for all bits; recombined state = 0x00000004_00000003_00000002_00000001.
REQ-033 d=3, random rnd, 1000 random states -> XOR of the 3 shares of every bit equals the applied plaintext; share 1 and share 2 equal the applied rnd.
REQ-034 rnd_valid=0 on cycles 2-3 of a load with in_valid held high -> in_ready=0 on those cycles; slot 1 takes the word presented when rnd_valid returns; out_valid is delayed by 2 cycles.
REQ-035 out_ready held 0 for 5 cycles in FULL while in_valid=1 with new data -> sh_state unchanged and in_ready=0; after out_ready=1, the next word goes to slot 0.
REQ-036 clear=1 after 2 accepted words, then 4 words -> exactly one out_valid, and the state contains only the 4 post-clear words.
REQ-037 rst_n pulsed low after 3 words -> out_valid=0 and sh_state all 0 immediately; the next 4 words produce a correct state.
